// File: rtl/genius_pkg.sv
// rtl/genius_pkg.sv - shared states, constants and helpers for the genius memory game
package genius_pkg;

    localparam int MAX_LEN = 16;
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD,
        ST_SHOW_ON,
        ST_SHOW_OFF,
        ST_INPUT,
        ST_WIN,
        ST_LOSE
    } state_t;

    // Active-low segment patterns, bit6..0 = g..a
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Fibonacci LFSR, taps 8,6,5,4
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Only three colours exist, so the fourth code folds onto colour 0
    function automatic logic [1:0] lfsr_symbol(input logic [7:0] v);
        return (v[1:0] == 2'd3) ? 2'd0 : v[1:0];
    endfunction

    // Split a 5-bit value into decimal tens (upper nibble) and units (lower nibble)
    function automatic logic [7:0] to_bcd2(input logic [4:0] v);
        logic [4:0] r;
        logic [3:0] t;
        t = 4'd0;
        r = v;
        if (r >= 5'd10) begin t = 4'd1; r = r - 5'd10; end
        if (r >= 5'd10) begin t = 4'd2; r = r - 5'd10; end
        if (r >= 5'd10) begin t = 4'd3; r = r - 5'd10; end
        return {t, 4'(r)};
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// rtl/seg7_dec.sv - decimal digit to active-low seven-segment pattern
module seg7_dec
    import genius_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Digits above 9 blank the display
    always_comb begin
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/genius.sv
// rtl/genius.sv - three-colour sequence memory game with level and best-score display
module genius
    import genius_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES    = 25_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] btn,
    input  logic [9:2] sw,
    output logic [6:0] segd0,
    output logic [6:0] segd1,
    output logic [6:0] segd2,
    output logic [6:0] segd3,
    output logic [9:0] leds
);

    state_t      state, state_n;
    logic [4:0]  level, level_n;
    logic [4:0]  best, best_n;
    logic [3:0]  idx, idx_n;
    logic [31:0] show_cnt, show_n;
    logic [31:0] tmo_cnt, tmo_n;
    logic [7:0]  lfsr;
    logic [1:0]  mem [MAX_LEN];

    logic        start_s1, start_s2;
    logic [2:0]  btn_s1, btn_s2;
    logic        start_edge;
    logic [2:0]  btn_edge;

    logic        mem_we, load_seed;
    logic [1:0]  cur_sym;
    logic        press_ok, idx_more;
    logic [4:0]  lose_score;
    logic [2:0]  lamps_n;

    logic [7:0]  level_bcd, best_bcd;
    logic [6:0]  seg_lu, seg_lt, seg_bu, seg_bt;

    assign start_edge = start_s1 & ~start_s2;
    assign btn_edge   = btn_s1 & ~btn_s2;
    assign cur_sym    = mem[idx];
    // A single edge on the expected colour; any other edge pattern is a mistake
    assign press_ok   = (btn_edge == (3'b001 << cur_sym));
    assign idx_more   = (({1'b0, idx} + 5'd1) < level);
    assign lose_score = level - 5'd1;

    // Synchronise the player inputs so only clean one-cycle edges reach the FSM
    always_ff @(posedge clock) begin
        if (reset) begin
            start_s1 <= 1'b0;
            start_s2 <= 1'b0;
            btn_s1   <= 3'b000;
            btn_s2   <= 3'b000;
        end else begin
            start_s1 <= start;
            start_s2 <= start_s1;
            btn_s1   <= btn;
            btn_s2   <= btn_s1;
        end
    end

    // Free-running LFSR, reseeded when a game actually begins
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else if (load_seed) begin
            lfsr <= (sw == 8'h00) ? LFSR_SEED : sw;
        end else begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    // Sequence memory append; contents are don't-care until written
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[level[3:0]] <= lfsr_symbol(lfsr);
        end
    end

    // Game state and counters
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            level    <= 5'd0;
            best     <= 5'd0;
            idx      <= 4'd0;
            show_cnt <= 32'd0;
            tmo_cnt  <= 32'd0;
        end else begin
            state    <= state_n;
            level    <= level_n;
            best     <= best_n;
            idx      <= idx_n;
            show_cnt <= show_n;
            tmo_cnt  <= tmo_n;
        end
    end

    // Next-state logic: start edges only count while no game is running
    always_comb begin
        state_n   = state;
        level_n   = level;
        best_n    = best;
        idx_n     = idx;
        show_n    = show_cnt;
        tmo_n     = tmo_cnt;
        mem_we    = 1'b0;
        load_seed = 1'b0;
        case (state)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (start_edge) begin
                    level_n   = 5'd0;
                    idx_n     = 4'd0;
                    show_n    = 32'd0;
                    tmo_n     = 32'd0;
                    load_seed = 1'b1;
                    state_n   = ST_ADD;
                end
            end
            ST_ADD: begin
                mem_we  = 1'b1;
                level_n = level + 5'd1;
                idx_n   = 4'd0;
                show_n  = 32'd0;
                state_n = ST_SHOW_ON;
            end
            ST_SHOW_ON: begin
                if (show_cnt == SHOW_CYCLES - 1) begin
                    show_n  = 32'd0;
                    state_n = ST_SHOW_OFF;
                end else begin
                    show_n = show_cnt + 32'd1;
                end
            end
            ST_SHOW_OFF: begin
                if (show_cnt == SHOW_CYCLES - 1) begin
                    show_n = 32'd0;
                    if (idx_more) begin
                        idx_n   = idx + 4'd1;
                        state_n = ST_SHOW_ON;
                    end else begin
                        idx_n   = 4'd0;
                        tmo_n   = 32'd0;
                        state_n = ST_INPUT;
                    end
                end else begin
                    show_n = show_cnt + 32'd1;
                end
            end
            ST_INPUT: begin
                if (btn_edge != 3'b000) begin
                    if (press_ok) begin
                        if (idx_more) begin
                            idx_n = idx + 4'd1;
                            tmo_n = 32'd0;
                        end else if (level == 5'(MAX_LEN)) begin
                            state_n = ST_WIN;
                            if (5'(MAX_LEN) > best) best_n = 5'(MAX_LEN);
                        end else begin
                            state_n = ST_ADD;
                        end
                    end else begin
                        state_n = ST_LOSE;
                        if (lose_score > best) best_n = lose_score;
                    end
                end else if (tmo_cnt == TIMEOUT_CYCLES - 1) begin
                    state_n = ST_LOSE;
                    if (lose_score > best) best_n = lose_score;
                end else begin
                    tmo_n = tmo_cnt + 32'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Colour lamps: replayed symbol while showing, live buttons while the player answers
    always_comb begin
        lamps_n = 3'b000;
        case (state)
            ST_SHOW_ON: lamps_n = 3'b001 << cur_sym;
            ST_INPUT:   lamps_n = btn_s1;
            default:    lamps_n = 3'b000;
        endcase
    end

    assign level_bcd = to_bcd2(level);
    assign best_bcd  = to_bcd2(best);

    seg7_dec u_seg_lu (.digit(level_bcd[3:0]), .seg(seg_lu));
    seg7_dec u_seg_lt (.digit(level_bcd[7:4]), .seg(seg_lt));
    seg7_dec u_seg_bu (.digit(best_bcd[3:0]),  .seg(seg_bu));
    seg7_dec u_seg_bt (.digit(best_bcd[7:4]),  .seg(seg_bt));

    // Registered outputs, one cycle behind the state they describe
    always_ff @(posedge clock) begin
        if (reset) begin
            leds  <= 10'b0;
            segd0 <= SEG_0;
            segd1 <= SEG_0;
            segd2 <= SEG_0;
            segd3 <= SEG_0;
        end else begin
            leds  <= {state == ST_LOSE,
                      state == ST_WIN,
                      (state == ST_ADD) || (state == ST_SHOW_ON) ||
                      (state == ST_SHOW_OFF) || (state == ST_INPUT),
                      4'b0000,
                      lamps_n};
            segd0 <= seg_lu;
            segd1 <= seg_lt;
            segd2 <= seg_bu;
            segd3 <= seg_bt;
        end
    end

endmodule

// File: tb/tb_genius.sv
// tb/tb_genius.sv - self-checking bench for genius
module tb_genius;
    import genius_pkg::*;

    localparam int S = 4;
    localparam int T = 64;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] btn = 3'b000;
    logic [9:2] sw = 8'h00;
    logic [6:0] segd0, segd1, segd2, segd3;
    logic [9:0] leds;

    genius #(.SHOW_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset), .start(start), .btn(btn), .sw(sw),
        .segd0(segd0), .segd1(segd1), .segd2(segd2), .segd3(segd3), .leds(leds)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Model of the game as the player sees it
    int         m_level = 0;
    int         m_best = 0;
    int         m_mode = 0;        // 0 idle, 1 playing, 2 win, 3 lose
    int         quiet_until = 0;   // generic checks resume once outputs have settled
    bit         show_on = 1'b0;
    int         show_t = 0;        // clock edge of the ADD that starts a replay
    int         show_len = 0;
    int         mirror_cyc = -1;
    logic [2:0] mirror_val = 3'b000;
    logic [1:0] seq [16];
    logic [7:0] seed_v = 8'hA5;
    int         t_load = 0;
    logic [6:0] seg_tab [10];

    initial begin
        seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
        seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
        seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] lfsr_adv(input logic [7:0] v, input int n);
        logic [7:0] x;
        x = v;
        for (int i = 0; i < n; i++) x = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
        return x;
    endfunction

    function automatic logic [1:0] sym_of(input logic [7:0] x);
        return (x[1:0] == 2'd3) ? 2'd0 : x[1:0];
    endfunction

    // Compare DUT outputs with the model every cycle they are defined
    always @(negedge clock) begin
        int k;
        logic [2:0] mb;
        if (cyc >= 1) begin
            if (show_on && cyc > show_t && cyc <= show_t + 2 * S * show_len) begin
                k = cyc - show_t - 1;
                check("show_lamps", {29'd0, leds[2:0]},
                      ((k % (2 * S)) < S) ? (32'd1 << seq[k / (2 * S)]) : 32'd0);
                check("show_playing", {31'd0, leds[7]}, 32'd1);
            end
            if (cyc == mirror_cyc) check("input_mirror", {29'd0, leds[2:0]}, {29'd0, mirror_val});
            if (cyc >= quiet_until) begin
                mb = (m_mode == 1) ? 3'b001 : (m_mode == 2) ? 3'b010 : (m_mode == 3) ? 3'b100 : 3'b000;
                check("status_leds", {29'd0, leds[9:7]}, {29'd0, mb});
                check("unused_leds", {28'd0, leds[6:3]}, 32'd0);
                if (m_mode != 1) check("idle_lamps", {29'd0, leds[2:0]}, 32'd0);
                check("segd0", {25'd0, segd0}, {25'd0, seg_tab[m_level % 10]});
                check("segd1", {25'd0, segd1}, {25'd0, seg_tab[m_level / 10]});
                check("segd2", {25'd0, segd2}, {25'd0, seg_tab[m_best % 10]});
                check("segd3", {25'd0, segd3}, {25'd0, seg_tab[m_best / 10]});
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    task automatic add_round(input int ta, input int len);
        seq[len - 1] = sym_of(lfsr_adv(seed_v, ta - t_load - 1));
        show_t   = ta;
        show_len = len;
        show_on  = 1'b1;
    endtask

    task automatic start_game(input logic [7:0] s);
        int p;
        p = cyc;
        sw = s;
        start = 1'b1;
        quiet_until = p + 6;
        seed_v = (s == 8'h00) ? 8'hA5 : s;
        t_load = p + 2;
        m_mode = 1;
        m_level = 1;
        add_round(p + 3, 1);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
    endtask

    task automatic press(input logic [2:0] mask, input bit last, input bit wrong);
        int p;
        p = cyc;
        btn = mask;
        if (wrong) begin
            quiet_until = p + 5;
            show_on = 1'b0;
            m_mode = 3;
            if (m_level - 1 > m_best) m_best = m_level - 1;
        end else if (!last) begin
            mirror_cyc = p + 2;
            mirror_val = mask;
        end else if (m_level == 16) begin
            quiet_until = p + 5;
            show_on = 1'b0;
            m_mode = 2;
            m_best = 16;
        end else begin
            quiet_until = p + 5;
            m_level = m_level + 1;
            add_round(p + 3, m_level);
        end
        @(negedge clock);
        @(negedge clock);
        btn = 3'b000;
        @(negedge clock);
    endtask

    task automatic play_round();
        int len;
        len = show_len;
        wait_cyc(show_t + 2 * S * len);
        for (int j = 0; j < len; j++) press(3'b001 << seq[j], j == len - 1, 1'b0);
    endtask

    initial begin
        int w;
        @(negedge clock);
        reset = 1'b0;
        check("reset_leds", {22'd0, leds}, 32'd0);
        check("reset_segd0", {25'd0, segd0}, 32'h40);
        check("reset_segd3", {25'd0, segd3}, 32'h40);
        check("reset_state", {29'd0, dut.state}, {29'd0, ST_IDLE});
        @(negedge clock);

        // Game A: default seed, one correct round, then a wrong colour
        start_game(8'h00);
        wait_cyc(show_t + 1);
        check("first_symbol_lamp", {29'd0, leds[2:0]}, 32'h2);
        check("level1_segd0", {25'd0, segd0}, 32'h79);
        check("level1_playing", {31'd0, leds[7]}, 32'd1);
        play_round();
        wait_cyc(show_t + 1);
        check("level2_segd0", {25'd0, segd0}, 32'h24);
        wait_cyc(show_t + 2 * S * 2);
        w = (int'(seq[0]) + 1) % 3;
        press(3'b001 << w, 1'b0, 1'b1);
        wait_cyc(cyc + 2);
        check("wrong_lose_led", {31'd0, leds[9]}, 32'd1);
        check("best1_segd2", {25'd0, segd2}, 32'h79);

        // Game B: two buttons rising together
        start_game(8'h3C);
        wait_cyc(show_t + 2 * S);
        press(3'b011, 1'b0, 1'b1);
        wait_cyc(cyc + 2);
        check("double_press_lose", {31'd0, leds[9]}, 32'd1);
        check("double_best_kept", {25'd0, segd2}, 32'h79);

        // Game C: no press until the timeout expires
        start_game(8'h81);
        wait_cyc(show_t + 2 * S + T);
        check("timeout_not_yet", {31'd0, leds[9]}, 32'd0);
        quiet_until = cyc + 2;
        m_mode = 3;
        @(negedge clock);
        check("timeout_lose", {31'd0, leds[9]}, 32'd1);
        @(negedge clock);

        // Game D: full correct play to the last level, then restart
        start_game(8'h5A);
        for (int l = 1; l <= 16; l++) play_round();
        wait_cyc(cyc + 2);
        check("win_led", {31'd0, leds[8]}, 32'd1);
        check("win_segd3", {25'd0, segd3}, 32'h79);
        check("win_segd2", {25'd0, segd2}, 32'h02);
        check("win_level_segd0", {25'd0, segd0}, 32'h02);
        start_game(8'h00);
        wait_cyc(show_t + 2);
        check("restart_segd0", {25'd0, segd0}, 32'h79);
        check("restart_segd1", {25'd0, segd1}, 32'h40);
        check("restart_best_segd3", {25'd0, segd3}, 32'h79);
        check("restart_best_segd2", {25'd0, segd2}, 32'h02);
        check("restart_playing", {31'd0, leds[7]}, 32'd1);
        wait_cyc(cyc + 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
